bit_shift_box_filter: RTL and testbench

Parametrised horizontal box (low-pass) filter that replaces the fixed-configuration bit-shift blur at the front of the light-field pipeline. It accepts NUM_CH packed unsigned channels per pixel and averages the last 2^ksel valid pixels of each image row using a running sum and a shift, with no divider. It emits unsigned fixed-point channels (default Q12.12) with the capture and light-field sideband flags aligned to the output. The kernel size is latched once per capture, and rows are left-edge replicated.

---
 rtl/bit_shift_box_filter.sv | 171 +++++++++++++++++
 tb/tb_bit_shift_box_filter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_shift_box_filter.sv
// Horizontal box filter over the last 2^K valid pixels of a row.
// A running sum per channel is updated with the newest pixel and the pixel
// leaving the window, then scaled by a shift into unsigned Q(OUT_INT_BITS).FRAC_BITS.
// Rows are left-edge replicated, and K is latched on each start-of-capture beat.
module bit_shift_box_filter #(
  parameter int NUM_CH       = 3,
  parameter int CH_WIDTH     = 8,
  parameter int OUT_INT_BITS = 12,
  parameter int FRAC_BITS    = 12,
  parameter int MAX_KSEL     = 3,
  parameter int IMG_WIDTH    = 640
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [$clog2(MAX_KSEL+1)-1:0]              ksel,
  input  logic                                       pixel_valid_in,
  input  logic                                       soc_in,
  input  logic                                       eoc_in,
  input  logic                                       solf_in,
  input  logic                                       eolf_in,
  input  logic [NUM_CH*CH_WIDTH-1:0]                 pixel_in,
  output logic                                       pixel_valid_out,
  output logic                                       soc_out,
  output logic                                       eoc_out,
  output logic                                       solf_out,
  output logic                                       eolf_out,
  output logic [NUM_CH*(OUT_INT_BITS+FRAC_BITS)-1:0] pixel_out,
  output logic [$clog2(MAX_KSEL+1)-1:0]              active_ksel,
  output logic                                       row_len_err
);

  localparam int KW       = $clog2(MAX_KSEL + 1);
  localparam int DEPTH    = 1 << MAX_KSEL;
  localparam int SUM_W    = CH_WIDTH + MAX_KSEL;
  localparam int OUT_W    = OUT_INT_BITS + FRAC_BITS;
  localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  // Front-end state (stage 1 holds the running sums)
  logic [COL_W-1:0]    col_q, col_d;
  logic [KW-1:0]       active_ksel_q, active_ksel_d;
  logic                err_q, err_d;
  logic [SUM_W-1:0]    sum_q  [NUM_CH];
  logic [SUM_W-1:0]    sum_d  [NUM_CH];
  logic [CH_WIDTH-1:0] hist_q [NUM_CH][DEPTH];
  logic [CH_WIDTH-1:0] hist_d [NUM_CH][DEPTH];
  logic                valid_s1_q;
  logic [3:0]          flags_s1_q;

  // Output stage
  logic                valid_s2_q;
  logic [3:0]          flags_s2_q;
  logic [NUM_CH*OUT_W-1:0] pixel_q, pixel_d;

  // Beat decode
  logic [CH_WIDTH-1:0] pix_ch [NUM_CH];
  logic [KW-1:0]       k_req;
  logic [KW-1:0]       k_eff;
  logic [COL_W-1:0]    col_beat;
  logic                row_start;
  logic [MAX_KSEL-1:0] tap_idx;

  // Requests beyond MAX_KSEL only exist when the ksel field has spare codes.
  if (((1 << KW) - 1) > MAX_KSEL) begin : g_clamp
    assign k_req = (ksel > KW'(MAX_KSEL)) ? KW'(MAX_KSEL) : ksel;
  end else begin : g_no_clamp
    assign k_req = ksel;
  end

  // Unpack channels, MSB-first
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pix_ch[c] = pixel_in[(NUM_CH-1-c)*CH_WIDTH +: CH_WIDTH];
    end
  end

  // The soc beat uses the freshly requested K and counts as column 0.
  always_comb begin
    k_eff     = soc_in ? k_req : active_ksel_q;
    col_beat  = soc_in ? '0 : col_q;
    row_start = (col_beat == '0);
    tap_idx   = '0;
    for (int i = 0; i < MAX_KSEL; i++) begin
      if (i < int'(k_eff)) tap_idx[i] = 1'b1;
    end
  end

  // Next-state for column, kernel latch, error flag, sums and history
  always_comb begin
    col_d         = col_q;
    active_ksel_d = active_ksel_q;
    err_d         = err_q;
    sum_d         = sum_q;
    hist_d        = hist_q;
    if (pixel_valid_in) begin
      active_ksel_d = k_eff;
      col_d         = (col_beat == LAST_COL) ? '0 : col_beat + COL_W'(1);
      if (soc_in) err_d = 1'b0;
      if (eoc_in && (col_beat != LAST_COL)) err_d = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (row_start) begin
          // Window pre-filled with the first pixel of the row
          sum_d[c] = SUM_W'(pix_ch[c]) << k_eff;
          for (int i = 0; i < DEPTH; i++) hist_d[c][i] = pix_ch[c];
        end else begin
          sum_d[c]     = sum_q[c] + SUM_W'(pix_ch[c]) - SUM_W'(hist_q[c][tap_idx]);
          hist_d[c][0] = pix_ch[c];
          for (int i = 1; i < DEPTH; i++) hist_d[c][i] = hist_q[c][i-1];
        end
      end
    end
  end

  // Stage 1: running state plus the beat's qualifier and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      active_ksel_q <= '0;
      err_q         <= 1'b0;
      valid_s1_q    <= 1'b0;
      flags_s1_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c] <= '0;
        for (int i = 0; i < DEPTH; i++) hist_q[c][i] <= '0;
      end
    end else begin
      col_q         <= col_d;
      active_ksel_q <= active_ksel_d;
      err_q         <= err_d;
      sum_q         <= sum_d;
      hist_q        <= hist_d;
      valid_s1_q    <= pixel_valid_in;
      flags_s1_q    <= pixel_valid_in ? {soc_in, eoc_in, solf_in, eolf_in} : 4'b0;
    end
  end

  // Scale the sum by 2^(FRAC_BITS-K); exact, since K never exceeds FRAC_BITS.
  // active_ksel_q still carries the K of the beat sitting in stage 1.
  always_comb begin
    pixel_d = pixel_q;
    if (valid_s1_q) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pixel_d[(NUM_CH-1-c)*OUT_W +: OUT_W] =
          OUT_W'(sum_q[c]) << (FRAC_BITS - int'(active_ksel_q));
      end
    end
  end

  // Stage 2: registered outputs; pixel holds across gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s2_q <= 1'b0;
      flags_s2_q <= '0;
      pixel_q    <= '0;
    end else begin
      valid_s2_q <= valid_s1_q;
      flags_s2_q <= flags_s1_q;
      pixel_q    <= pixel_d;
    end
  end

  assign pixel_valid_out = valid_s2_q;
  assign soc_out         = flags_s2_q[3];
  assign eoc_out         = flags_s2_q[2];
  assign solf_out        = flags_s2_q[1];
  assign eolf_out        = flags_s2_q[0];
  assign pixel_out       = pixel_q;
  assign active_ksel     = active_ksel_q;
  assign row_len_err     = err_q;

endmodule

// File: tb/tb_bit_shift_box_filter.sv
// Self-checking bench for bit_shift_box_filter with a 4-pixel row.
// The reference model keeps the current row as a list and averages the last
// 2^K entries directly, padding before the row start with the first pixel.
module tb_bit_shift_box_filter;

  localparam int NC  = 3;
  localparam int CW  = 8;
  localparam int OIB = 12;
  localparam int FB  = 12;
  localparam int MK  = 3;
  localparam int W   = 4;
  localparam int OW  = OIB + FB;
  localparam int KW  = $clog2(MK + 1);
  localparam int PW  = NC * CW;
  localparam int QW  = NC * OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] ksel = '0;
  logic          pixel_valid_in = 1'b0;
  logic          soc_in = 1'b0, eoc_in = 1'b0, solf_in = 1'b0, eolf_in = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          pixel_valid_out;
  logic          soc_out, eoc_out, solf_out, eolf_out;
  logic [QW-1:0] pixel_out;
  logic [KW-1:0] active_ksel;
  logic          row_len_err;

  always #5 clk = ~clk;

  bit_shift_box_filter #(
    .NUM_CH(NC), .CH_WIDTH(CW), .OUT_INT_BITS(OIB), .FRAC_BITS(FB),
    .MAX_KSEL(MK), .IMG_WIDTH(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ksel(ksel),
    .pixel_valid_in(pixel_valid_in),
    .soc_in(soc_in), .eoc_in(eoc_in), .solf_in(solf_in), .eolf_in(eolf_in),
    .pixel_in(pixel_in),
    .pixel_valid_out(pixel_valid_out),
    .soc_out(soc_out), .eoc_out(eoc_out), .solf_out(solf_out), .eolf_out(eolf_out),
    .pixel_out(pixel_out), .active_ksel(active_ksel), .row_len_err(row_len_err)
  );

  typedef struct {
    bit            valid;
    logic [QW-1:0] pix;
    logic [3:0]    flags;
  } exp_t;

  exp_t          pipe[$];
  logic [PW-1:0] row_q[$];
  logic [QW-1:0] obs[$];
  logic [QW-1:0] ref_obs[$];
  logic [OW-1:0] ev[$];
  logic [QW-1:0] last_out;
  int            m_col, m_k;
  bit            m_err;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int chan(input logic [PW-1:0] p, input int c);
    return int'(p[(NC-1-c)*CW +: CW]);
  endfunction

  // Reference: average of the last 2^K pixels of the row, first pixel replicated
  task automatic model_beat(input bit s, input bit e, input logic [PW-1:0] pix,
                            output logic [QW-1:0] r);
    int beat_col, n, idx, acc, j2;
    if (s) begin
      m_k   = (int'(ksel) > MK) ? MK : int'(ksel);
      m_col = 0;
    end
    beat_col = m_col;
    if (beat_col == 0) row_q.delete();
    row_q.push_back(pix);
    if (s) m_err = 1'b0;
    if (e && beat_col != W - 1) m_err = 1'b1;
    n   = 1 << m_k;
    idx = row_q.size() - 1;
    r   = '0;
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int j = 0; j < n; j++) begin
        j2 = (idx - j < 0) ? 0 : idx - j;
        acc += chan(row_q[j2], c);
      end
      r[(NC-1-c)*OW +: OW] = OW'(acc << (FB - m_k));
    end
    m_col = (beat_col == W - 1) ? 0 : beat_col + 1;
  endtask

  // One clock: drive at the falling edge, check on the next falling edge
  task automatic step(input bit v, input bit s, input bit e, input bit sl, input bit el,
                      input logic [PW-1:0] pix);
    exp_t x, o;
    pixel_valid_in = v;
    soc_in  = s;
    eoc_in  = e;
    solf_in = sl;
    eolf_in = el;
    pixel_in = pix;
    x.valid = v;
    x.flags = v ? {s, e, sl, el} : 4'b0;
    x.pix   = '0;
    if (v) model_beat(s, e, pix, x.pix);
    pipe.push_back(x);
    @(posedge clk);
    @(negedge clk);
    if (pipe.size() >= 2) begin
      o = pipe.pop_front();
      check("valid_out", 128'(pixel_valid_out), 128'(o.valid));
      check("flags_out", 128'({soc_out, eoc_out, solf_out, eolf_out}), 128'(o.flags));
      if (o.valid) begin
        check("pixel_out", 128'(pixel_out), 128'(o.pix));
        last_out = o.pix;
      end else begin
        check("pixel_hold", 128'(pixel_out), 128'(last_out));
      end
    end
    if (pixel_valid_out) obs.push_back(pixel_out);
    check("active_ksel", 128'(active_ksel), 128'(m_k));
    check("row_len_err", 128'(row_len_err), 128'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic beat(input bit s, input bit e, input logic [CW-1:0] v);
    step(1'b1, s, e, 1'b0, 1'b0, {NC{v}});
  endtask

  task automatic rand_step(input int pct_valid);
    ksel = KW'($urandom_range(0, (1 << KW) - 1));
    step(($urandom_range(0, 99) < pct_valid),
         ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
         ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
         PW'($urandom));
  endtask

  // Assert reset asynchronously, check every output is cleared, then release
  task automatic do_reset();
    exp_t idle_e;
    rst_n = 1'b0;
    pixel_valid_in = 1'b0;
    soc_in = 1'b0; eoc_in = 1'b0; solf_in = 1'b0; eolf_in = 1'b0;
    #2;
    check("rst_valid", 128'(pixel_valid_out), 128'(0));
    check("rst_pixel", 128'(pixel_out), 128'(0));
    check("rst_flags", 128'({soc_out, eoc_out, solf_out, eolf_out}), 128'(0));
    check("rst_err", 128'(row_len_err), 128'(0));
    check("rst_ksel", 128'(active_ksel), 128'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_col = 0; m_k = 0; m_err = 1'b0;
    row_q.delete();
    last_out = '0;
    pipe.delete();
    idle_e.valid = 1'b0; idle_e.pix = '0; idle_e.flags = '0;
    pipe.push_back(idle_e);
    obs.delete();
  endtask

  // Compare collected outputs with a list of per-channel constants
  task automatic expect_outs(input string tag);
    check({tag, "_count"}, 128'(obs.size()), 128'(ev.size()));
    for (int i = 0; i < ev.size() && i < obs.size(); i++)
      check(tag, 128'(obs[i]), 128'({NC{ev[i]}}));
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Random traffic, then reset with beats still in flight
    for (int i = 0; i < 40; i++) rand_step(75);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PW'($urandom));
    do_reset();

    // Flat row of 8 with K=2
    ksel = 2;
    obs.delete();
    beat(1, 0, 8'd8); beat(0, 0, 8'd8); beat(0, 0, 8'd8); beat(0, 0, 8'd8);
    idle(2);
    ev = '{24'h008000, 24'h008000, 24'h008000, 24'h008000};
    expect_outs("flat8");

    // Edge replication; the fifth beat wraps into a new row
    obs.delete();
    beat(1, 0, 8'd16); beat(0, 0, 8'd0); beat(0, 0, 8'd0); beat(0, 0, 8'd0); beat(0, 0, 8'd0);
    idle(2);
    ev = '{24'h010000, 24'h00C000, 24'h008000, 24'h004000, 24'h000000};
    expect_outs("edge");

    // Fractional result with K=1
    ksel = 1;
    obs.delete();
    beat(1, 0, 8'd1); beat(0, 0, 8'd2);
    idle(2);
    ev = '{24'h001000, 24'h001800};
    expect_outs("frac");

    // K latched at soc; mid-capture request ignored; largest code at next soc
    ksel = 2;
    obs.delete();
    beat(1, 0, 8'd0);
    ksel = 0;
    beat(0, 0, 8'd16); beat(0, 0, 8'd16); beat(0, 0, 8'd16);
    check("ksel_held", 128'(active_ksel), 128'(2));
    ksel = KW'((1 << KW) - 1);
    beat(1, 0, 8'd0);
    check("ksel_clamp", 128'(active_ksel), 128'(MK));
    beat(0, 0, 8'd16);
    idle(2);
    ev = '{24'h000000, 24'h004000, 24'h008000, 24'h00C000, 24'h000000, 24'h002000};
    expect_outs("latch");

    // Gaps must not change the result: gap-free reference run first
    ksel = 1;
    begin
      logic [PW-1:0] seq[12];
      for (int i = 0; i < 12; i++) seq[i] = PW'($urandom);
      obs.delete();
      for (int i = 0; i < 12; i++) step(1'b1, (i == 0), 1'b0, 1'b0, 1'b0, seq[i]);
      idle(2);
      ref_obs = obs;
      obs.delete();
      for (int i = 0; i < 12; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          step(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1, 1'b1, PW'($urandom));
        step(1'b1, (i == 0), 1'b0, 1'b0, 1'b0, seq[i]);
      end
      idle(2);
      check("gap_count", 128'(obs.size()), 128'(ref_obs.size()));
      for (int i = 0; i < obs.size() && i < ref_obs.size(); i++)
        check("gap_equal", 128'(obs[i]), 128'(ref_obs[i]));
    end

    // Row wrap: column 4 restarts replication
    ksel = 2;
    obs.delete();
    beat(1, 0, 8'd200); idle(1); beat(0, 0, 8'd200); beat(0, 0, 8'd200); idle(2);
    beat(0, 0, 8'd200); idle(1); beat(0, 0, 8'd5);
    idle(2);
    check("wrap_count", 128'(obs.size()), 128'(5));
    if (obs.size() == 5) check("wrap_first", 128'(obs[4]), 128'({NC{24'h005000}}));

    // Short row sets the sticky error; next soc clears it; a full row does not set it
    ksel = 0;
    beat(1, 0, 8'd3); beat(0, 0, 8'd3); beat(0, 1, 8'd3);
    check("err_set", 128'(row_len_err), 128'(1));
    idle(2);
    check("err_sticky", 128'(row_len_err), 128'(1));
    beat(1, 0, 8'd3);
    check("err_clear", 128'(row_len_err), 128'(0));
    beat(0, 0, 8'd3); beat(0, 0, 8'd3); beat(0, 1, 8'd3);
    check("err_full_row", 128'(row_len_err), 128'(0));
    beat(1, 1, 8'd3);
    check("err_soc_eoc", 128'(row_len_err), 128'(1));
    idle(2);

    // Long random run against the model
    for (int i = 0; i < 400; i++) rand_step(75);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
